// File: rtl/adder_fu_sched_if.sv
// Requester/response bus and adder-slice link of the shared adder scheduler.
// slave: scheduler view; master: requesters plus adder slice.
interface adder_fu_sched_if #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 2,
  parameter int NREQ   = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OPW = NREQ * NWORDS * WIDTH;

  logic [NREQ-1:0]         req;
  logic [OPW-1:0]          req_a;
  logic [OPW-1:0]          req_b;
  logic [NREQ-1:0]         req_cin;
  logic [NREQ-1:0]         req_cin_en;
  logic [NREQ-1:0]         gnt;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [NWORDS*WIDTH-1:0] rsp_sum;
  logic                    rsp_cout;
  logic                    err;

  logic [WIDTH-1:0]        fu_a;
  logic [WIDTH-1:0]        fu_b;
  logic                    fu_carry_in;
  logic                    fu_carry_listen;
  logic                    fu_on_off;
  logic [WIDTH-1:0]        fu_c;
  logic                    fu_carry_out;
  logic                    fu_ack;

  modport slave (
    input  req, req_a, req_b, req_cin, req_cin_en,
    output gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, err,
    output fu_a, fu_b, fu_carry_in, fu_carry_listen, fu_on_off,
    input  fu_c, fu_carry_out, fu_ack
  );

  modport master (
    output req, req_a, req_b, req_cin, req_cin_en,
    input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, err,
    input  fu_a, fu_b, fu_carry_in, fu_carry_listen, fu_on_off,
    output fu_c, fu_carry_out, fu_ack
  );
endinterface

// File: rtl/adder_fu_sched.sv
// Round-robin scheduler streaming wide adds LSB-first through one
// shared W-bit adder slice, carry chained from the slice's registered carry.
module adder_fu_sched #(
  parameter int WIDTH  = 16,
  parameter int NWORDS = 2,
  parameter int NREQ   = 4
) (
  input logic             clk,
  input logic             reset,
  adder_fu_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int KW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int DW  = NWORDS * WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            cin_q, cin_d;
  logic            cen_q, cen_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   res_q, res_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            vld_q, vld_d;
  logic [IDW-1:0]  rid_q, rid_d;
  logic [DW-1:0]   sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic            win_vld;
  logic [IDW-1:0]  win_id;

  // search starts one past the last winner
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int j = 0; j < NREQ; j++) begin
      idx = (int'(rr_q) + j) % NREQ;
      if (!win_vld && bus.req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    cen_d   = cen_q;
    id_d    = id_q;
    res_d   = res_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    rid_d   = rid_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    bus.fu_on_off       = 1'b0;
    bus.fu_a            = '0;
    bus.fu_b            = '0;
    bus.fu_carry_in     = 1'b0;
    bus.fu_carry_listen = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          a_d     = bus.req_a[win_id*DW +: DW];
          b_d     = bus.req_b[win_id*DW +: DW];
          cin_d   = bus.req_cin[win_id];
          cen_d   = bus.req_cin_en[win_id];
          id_d    = win_id;
          gnt_d   = NREQ'(1) << win_id;
          k_d     = '0;
          rr_d    = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.fu_on_off = 1'b1;
        bus.fu_a      = a_q[k_q*WIDTH +: WIDTH];
        bus.fu_b      = b_q[k_q*WIDTH +: WIDTH];
        if (k_q == '0) begin
          bus.fu_carry_listen = cen_q;
          bus.fu_carry_in     = cin_q;
        end else begin
          bus.fu_carry_listen = 1'b1;
          bus.fu_carry_in     = bus.fu_carry_out;
          res_d[(k_q-1)*WIDTH +: WIDTH] = bus.fu_c;
          if (!bus.fu_ack) err_d = 1'b1;
        end
        if (k_q == KW'(NWORDS-1)) begin
          k_d     = '0;
          state_d = DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        bus.fu_on_off = 1'b1;
        res_d[(NWORDS-1)*WIDTH +: WIDTH] = bus.fu_c;
        if (!bus.fu_ack) err_d = 1'b1;
        sum_d   = res_d;
        cout_d  = bus.fu_carry_out;
        rid_d   = id_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      cen_q   <= 1'b0;
      id_q    <= '0;
      res_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      rid_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      cen_q   <= cen_d;
      id_q    <= id_d;
      res_q   <= res_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      rid_q   <= rid_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_adder_fu_sched.sv
// Directed bench for adder_fu_sched with a behavioural registered
// adder slice and a grant/response scoreboard.
module tb_adder_fu_sched;
  localparam int W   = 16;
  localparam int NW  = 2;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int DW  = NW * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_fu_sched_if #(.WIDTH(W), .NWORDS(NW), .NREQ(NR)) sif();

  adder_fu_sched #(.WIDTH(W), .NWORDS(NW), .NREQ(NR)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (sif)
  );

  logic [DW-1:0] opa [NR];
  logic [DW-1:0] opb [NR];
  logic [NR-1:0] req, cin, cen;
  logic          ack_kill;
  logic          ack_q;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign sif.req_a[g*DW +: DW] = opa[g];
    assign sif.req_b[g*DW +: DW] = opb[g];
  end
  assign sif.req        = req;
  assign sif.req_cin    = cin;
  assign sif.req_cin_en = cen;

  // registered adder slice; off clears its outputs
  always_ff @(posedge clk) begin
    if (!sif.fu_on_off) begin
      sif.fu_c         <= '0;
      sif.fu_carry_out <= 1'b0;
      ack_q            <= 1'b0;
    end else begin
      {sif.fu_carry_out, sif.fu_c} <= {1'b0, sif.fu_a} + {1'b0, sif.fu_b}
        + (W+1)'(sif.fu_carry_listen & sif.fu_carry_in);
      ack_q <= 1'b1;
    end
  end
  assign sif.fu_ack = ack_q & ~ack_kill;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int q_id[$];
  int q_cyc[$];
  int g_log[$];
  int g_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [DW:0] s;
    int id, c;
    @(posedge clk);
    #1;
    cyc++;
    if (sif.gnt != '0) begin
      chk("gnt_1hot", 64'($countones(sif.gnt)), 64'd1);
      for (int i = 0; i < NR; i++)
        if (sif.gnt[i]) begin
          q_id.push_back(i);
          q_cyc.push_back(cyc);
          g_log.push_back(i);
          g_cyc.push_back(cyc);
        end
    end
    if (sif.rsp_valid) begin
      if (q_id.size() == 0) begin
        chk("rsp_unexp", 64'(sif.rsp_valid), 64'd0);
      end else begin
        id = q_id.pop_front();
        c  = q_cyc.pop_front();
        s  = {1'b0, opa[id]} + {1'b0, opb[id]} + (DW+1)'(cin[id] & cen[id]);
        chk("rsp_id", 64'(sif.rsp_id), 64'(id));
        chk("rsp_sum", 64'(sif.rsp_sum), 64'(s[DW-1:0]));
        chk("rsp_cout", 64'(sif.rsp_cout), 64'(s[DW]));
        chk("rsp_lat", 64'(cyc - c), 64'd3);
      end
    end
  endtask

  task automatic wait_gnt(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (sif.gnt != '0) break;
    end
    chk("gnt_seen", 64'(sif.gnt != '0), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && q_id.size() != 0; i++) step();
    chk("rsp_drain", 64'(q_id.size()), 64'd0);
  endtask

  initial begin
    req = '0; cin = '0; cen = '0; ack_kill = 1'b0;
    for (int i = 0; i < NR; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", 64'({sif.gnt, sif.rsp_valid, sif.rsp_id, sif.rsp_sum,
                         sif.rsp_cout, sif.err}), 64'd0);
    chk("rst_fu", 64'({sif.fu_on_off, sif.fu_a, sif.fu_b, sif.fu_carry_in,
                       sif.fu_carry_listen}), 64'd0);
    rst_n = 1'b1;
    step();

    // carry across word boundary, no carry-in
    opa[1] = 32'h0000_FFFF; opb[1] = 32'h0000_0001;
    req[1] = 1'b1;
    wait_gnt(10);
    chk("t1_gnt", 64'(sif.gnt), 64'b0010);
    req[1] = 1'b0;
    step();
    chk("t1_gnt_pulse", 64'(sif.gnt), 64'd0);
    wait_idle(10);
    chk("t1_sum", 64'(sif.rsp_sum), 64'h0001_0000);
    chk("t1_id", 64'(sif.rsp_id), 64'd1);
    chk("t1_cout", 64'(sif.rsp_cout), 64'd0);
    step();
    chk("t1_vld_low", 64'(sif.rsp_valid), 64'd0);
    chk("t1_hold", 64'(sif.rsp_sum), 64'h0001_0000);

    // carry-in rippling through both words
    opa[3] = 32'hFFFF_FFFF; opb[3] = '0; cin[3] = 1'b1; cen[3] = 1'b1;
    req[3] = 1'b1;
    wait_gnt(10);
    chk("t2_gnt", 64'(sif.gnt), 64'b1000);
    req[3] = 1'b0;
    chk("t2_k0_cin", 64'({sif.fu_carry_listen, sif.fu_carry_in}), 64'b11);
    step();
    chk("t2_k1_cin", 64'({sif.fu_carry_listen, sif.fu_carry_in}), 64'b11);
    wait_idle(10);
    chk("t2_sum", 64'(sif.rsp_sum), 64'd0);
    chk("t2_cout", 64'(sif.rsp_cout), 64'd1);

    // two requesters held high: alternate back to back
    opa[0] = 32'h1234_5678; opb[0] = 32'h1111_1111;
    opa[2] = 32'h8000_0000; opb[2] = 32'h8000_0001;
    cin[2] = 1'b1; cen[2] = 1'b1;
    g_log.delete(); g_cyc.delete();
    req[0] = 1'b1; req[2] = 1'b1;
    for (int i = 0; i < 40 && g_log.size() < 4; i++) begin
      step();
      if (g_log.size() > 0)
        chk("t3_on_off", 64'(sif.fu_on_off),
            64'(((cyc - g_cyc[0]) % 4) != 3));
    end
    req[0] = 1'b0; req[2] = 1'b0;
    chk("t3_ngnt", 64'(g_log.size()), 64'd4);
    if (g_log.size() == 4) begin
      chk("t3_order", 64'({4'(g_log[0]), 4'(g_log[1]), 4'(g_log[2]),
                           4'(g_log[3])}), 64'h0202);
      for (int i = 1; i < 4; i++)
        chk("t3_gap", 64'(g_cyc[i] - g_cyc[i-1]), 64'd4);
    end
    wait_idle(10);

    // reset restarts the pointer at 0; all four at once
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    opa[0] = 32'h0000_0001; opb[0] = 32'h0000_0002;
    opa[1] = 32'hABCD_0000; opb[1] = 32'h0000_EF01;
    opa[2] = 32'h7FFF_FFFF; opb[2] = 32'h0000_0001; cen[2] = 1'b0;
    opa[3] = 32'hFFFF_0000; opb[3] = 32'h0001_FFFF; cen[3] = 1'b1;
    g_log.delete(); g_cyc.delete();
    req = 4'hF;
    for (int i = 0; i < 40 && g_log.size() < 4; i++) begin
      step();
      req = req & ~sif.gnt;
    end
    req = '0;
    chk("t4_ngnt", 64'(g_log.size()), 64'd4);
    if (g_log.size() == 4)
      chk("t4_order", 64'({4'(g_log[0]), 4'(g_log[1]), 4'(g_log[2]),
                           4'(g_log[3])}), 64'h0123);
    wait_idle(10);
    chk("t4_last_sum", 64'(sif.rsp_sum), 64'h0001_0000);
    chk("t4_last_cout", 64'(sif.rsp_cout), 64'd1);

    // dropped ack at the word-0 capture edge
    opa[1] = 32'h0002_8000; opb[1] = 32'h0003_8000;
    req[1] = 1'b1;
    wait_gnt(10);
    req[1] = 1'b0;
    step();
    ack_kill = 1'b1;
    chk("t5_err_pre", 64'(sif.err), 64'd0);
    step();
    ack_kill = 1'b0;
    chk("t5_err_set", 64'(sif.err), 64'd1);
    wait_idle(10);
    chk("t5_sum", 64'(sif.rsp_sum), 64'h0006_0000);
    repeat (3) step();
    chk("t5_err_stick", 64'(sif.err), 64'd1);

    // reset during ISSUE k=1 drops the add
    req[0] = 1'b1;
    wait_gnt(10);
    req[0] = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    q_id.delete(); q_cyc.delete();
    chk("t6_rst_outs", 64'({sif.gnt, sif.rsp_valid, sif.rsp_id, sif.rsp_sum,
                            sif.rsp_cout, sif.err}), 64'd0);
    chk("t6_rst_fu", 64'({sif.fu_on_off, sif.fu_a, sif.fu_b,
                          sif.fu_carry_in, sif.fu_carry_listen}), 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    g_log.delete(); g_cyc.delete();
    repeat (6) step();
    chk("t6_quiet", 64'(g_log.size()), 64'd0);
    opa[2] = 32'h0F0F_F0F0; opb[2] = 32'h0101_1010; cin[2] = 1'b1;
    cen[2] = 1'b1;
    req[2] = 1'b1;
    wait_gnt(10);
    chk("t6_gnt", 64'(sif.gnt), 64'b0100);
    req[2] = 1'b0;
    wait_idle(10);
    chk("t6_sum", 64'(sif.rsp_sum), 64'h1011_0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
